// File: rtl/obtc_hdr_pkg.sv
// Shared types and helpers for the block-header read path.
// Holds the header geometry constants, the reader state encoding and the word byte-swap.
package obtc_hdr_pkg;

    localparam int WORD_W    = 32;
    localparam int HDR_WORDS = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } hdr_rd_state_t;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fifo_hdr_reader.sv
// Drains 32-bit FWFT FIFO words and assembles WORDS of them into one header behind a valid/ready handshake.
// Optional mid-frame starvation timeout is enabled by defining FIFO_HDR_RD_TIMEOUT_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | not collecting; waits for en
//  COLLECT | popping words into hdr_data at index cnt
//  HOLD    | header complete, hdr_valid high, FIFO back-pressured
module fifo_hdr_reader
    import obtc_hdr_pkg::*;
#(
    parameter int WORDS   = HDR_WORDS,
    parameter int BSWAP   = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                    rd_clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [WORD_W-1:0]       fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [WORDS*WORD_W-1:0] hdr_data,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
    output logic [15:0]             frame_cnt,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int            IW   = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    if (WORDS < 2 || WORDS > 64 || TIMEOUT < 2) begin : g_bad_param
        $error("fifo_hdr_reader: WORDS must be 2..64 and TIMEOUT >= 2");
    end

    hdr_rd_state_t     state;
    hdr_rd_state_t     state_nxt;
    logic [IW-1:0]     cnt;
    logic              pop;
    logic              frame_done;
    logic              accept;
    logic              tmo_fire;
    logic [WORD_W-1:0] word_in;

    assign fifo_rd_en = (state == COLLECT) && !fifo_empty && !flush;
    assign pop        = fifo_rd_en;
    assign busy       = (state != IDLE);
    assign word_in    = (BSWAP != 0) ? bswap32(fifo_dout) : fifo_dout;

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        accept     = 1'b0;
        if (flush) begin
            state_nxt = en ? COLLECT : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state_nxt = COLLECT;
                end
                COLLECT: begin
                    if (pop && cnt == LAST) begin
                        frame_done = 1'b1;
                        state_nxt  = HOLD;
                    end else if (!pop && cnt == '0 && !en) begin
                        state_nxt = IDLE;
                    end
                end
                HOLD: begin
                    if (hdr_valid && hdr_ready) begin
                        accept    = 1'b1;
                        state_nxt = en ? COLLECT : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hdr_data  <= '0;
            hdr_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt       <= '0;
                hdr_valid <= 1'b0;
            end else if (pop) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (cnt == IW'(k)) hdr_data[WORD_W*(WORDS-1-k) +: WORD_W] <= word_in;
                end
                cnt <= frame_done ? '0 : cnt + IW'(1);
                if (frame_done) hdr_valid <= 1'b1;
            end else if (accept) begin
                hdr_valid <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (tmo_fire) begin
                cnt <= '0;
            end
        end
    end

`ifdef FIFO_HDR_RD_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

    // Down-counter: reloads on any pop, flush or empty frame, fires at terminal count zero.
    logic [15:0] to_cnt;

    assign tmo_fire = (state == COLLECT) && !flush && !pop && (cnt != '0) && (to_cnt == 16'd0);

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= TO_LOAD;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= tmo_fire;
            if (flush || pop || cnt == '0 || tmo_fire) begin
                to_cnt <= TO_LOAD;
            end else if (state == COLLECT) begin
                to_cnt <= to_cnt - 16'd1;
            end
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_hdr_reader.sv
// Randomized self-checking bench for fifo_hdr_reader against a queue-based header model.
// Builds with or without FIFO_HDR_RD_TIMEOUT_EN; the model follows the same define.
module tb_fifo_hdr_reader;

    localparam int WORDS = 20;
    localparam int HW    = WORDS * 32;
    localparam int TOUT  = 16;
`ifdef FIFO_HDR_RD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          rd_clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic [31:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [HW-1:0] hdr_data;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [15:0]   frame_cnt;
    logic          busy;
    logic          err_timeout;

    fifo_hdr_reader #(.WORDS(WORDS), .BSWAP(1), .TIMEOUT(TOUT)) dut (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .hdr_data   (hdr_data),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 rd_clk = ~rd_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO contents and the reference model
    typedef enum {M_IDLE, M_COL, M_HOLD} mstate_t;
    logic [31:0] fq[$];
    logic [31:0] m_part[$];
    logic [31:0] m_hdr[WORDS];
    mstate_t     m_state;
    logic        m_valid;
    logic        m_err;
    logic [15:0] m_fc;
    int          m_run;
    logic        force_empty;
    int          dpops;
    int          n_tmo;

    function automatic logic [HW-1:0] packed_hdr();
        logic [HW-1:0] v;
        v = '0;
        for (int k = 0; k < WORDS; k++) v[32*(WORDS-1-k) +: 32] = m_hdr[k];
        return v;
    endfunction

    task automatic model_reset();
        m_part.delete();
        for (int k = 0; k < WORDS; k++) m_hdr[k] = 32'h0;
        m_state = M_IDLE;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_fc    = 16'h0;
        m_run   = 0;
    endtask

    task automatic model_edge(input logic pop, input logic [31:0] w);
        logic [31:0] sw;
        m_err = 1'b0;
        if (flush) begin
            m_part.delete();
            m_valid = 1'b0;
            m_run   = 0;
            m_state = en ? M_COL : M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (en) m_state = M_COL;
                M_COL: begin
                    if (pop) begin
                        sw = {<<8{w}};
                        m_hdr[m_part.size()] = sw;
                        m_part.push_back(sw);
                        m_run = 0;
                        if (m_part.size() == WORDS) begin
                            m_valid = 1'b1;
                            m_part.delete();
                            m_state = M_HOLD;
                        end
                    end else if (m_part.size() == 0) begin
                        m_run = 0;
                        if (!en) m_state = M_IDLE;
                    end else begin
                        m_run++;
                        if (TO_EN && m_run == TOUT) begin
                            m_part.delete();
                            m_err = 1'b1;
                            m_run = 0;
                        end
                    end
                end
                M_HOLD: begin
                    if (hdr_ready) begin
                        m_valid = 1'b0;
                        m_fc    = m_fc + 16'd1;
                        m_state = en ? M_COL : M_IDLE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("hdr_valid", hdr_valid, m_valid);
        chk("hdr_data", hdr_data, packed_hdr());
        chk("frame_cnt", frame_cnt, m_fc);
        chk("busy", busy, m_state != M_IDLE);
        chk("err_timeout", err_timeout, m_err);
    endtask

    // One clock: drive at the falling edge, check the pop strobe, then the registered outputs after the rise.
    task automatic step();
        logic exp_pop;
        fifo_empty = force_empty || (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 32'h0;
        #1;
        exp_pop = (m_state == M_COL) && !fifo_empty && !flush;
        chk("fifo_rd_en", fifo_rd_en, exp_pop);
        dpops += int'(fifo_rd_en);
        @(posedge rd_clk);
        model_edge(exp_pop, fifo_dout);
        if (exp_pop) void'(fq.pop_front());
        #1;
        n_tmo += int'(err_timeout);
        check_outputs();
        @(negedge rd_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) fq.push_back($urandom());
    endtask

    task automatic handshake();
        hdr_ready = 1'b1;
        run(1);
        hdr_ready = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hdr_valid", hdr_valid, 1'b0);
        chk("rst_hdr_data", hdr_data, '0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        model_reset();
        @(negedge rd_clk);
        rst_n = 1'b1;
    endtask

    logic [HW-1:0] snap;

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; hdr_ready = 1'b0; force_empty = 1'b0;
        fifo_empty = 1'b1; fifo_dout = 32'h0; dpops = 0; n_tmo = 0;
        model_reset();
        repeat (3) @(negedge rd_clk);
        rst_n = 1'b1;
        #1;
        check_outputs();

        // first frame with the ramp pattern
        for (int k = 0; k < WORDS; k++) fq.push_back(32'h00010203 + 32'(k) * 32'h04040404);
        en = 1'b1;
        run(22);
        chk("t1_valid", hdr_valid, 1'b1);
        chk("t1_word0", hdr_data[HW-1 -: 32], 32'h03020100);
        handshake();
        chk("t1_frame_cnt", frame_cnt, 16'd1);

        // back-pressure while a header is held
        push_rand(40);
        run(21);
        snap  = hdr_data;
        dpops = 0;
        run(50);
        chk("t2_hold_pops", dpops, 0);
        chk("t2_stable", hdr_data, snap);
        handshake();
        chk("t2_frame_cnt", frame_cnt, 16'd2);
        dpops = 0;
        run(21);
        chk("t2_pops", dpops, 20);
        handshake();

        // gappy FIFO
        dpops = 0;
        push_rand(20);
        for (int i = 0; i < 45; i++) begin
            force_empty = (i % 2) == 1;
            run(1);
        end
        force_empty = 1'b0;
        chk("t3_pops", dpops, 20);
        chk("t3_valid", hdr_valid, 1'b1);
        handshake();

        // flush a partial frame
        push_rand(7);
        run(7);
        flush = 1'b1; run(1); flush = 1'b0;
        chk("t4_fc_after_flush", frame_cnt, 16'd4);
        push_rand(20);
        run(21);
        chk("t4_valid", hdr_valid, 1'b1);
        handshake();

        // flush beats a simultaneous handshake
        push_rand(20);
        run(21);
        hdr_ready = 1'b1; flush = 1'b1;
        run(1);
        hdr_ready = 1'b0; flush = 1'b0;
        chk("t5_valid", hdr_valid, 1'b0);
        chk("t5_frame_cnt", frame_cnt, 16'd5);

        // starvation mid-frame
        n_tmo = 0;
        push_rand(5);
        run(25);
        chk("t6_pulses", n_tmo, TO_EN ? 1 : 0);
        push_rand(20);
        run(30);
        chk("t6_valid", hdr_valid, 1'b1);
        handshake();

        // asynchronous reset mid-frame and in HOLD
        push_rand(10);
        run(5);
        async_reset();
        push_rand(20);
        run(30);
        chk("t7_valid", hdr_valid, 1'b1);
        async_reset();
        run(3);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            hdr_ready   = ($urandom_range(0, 2) == 0);
            force_empty = ($urandom_range(0, 3) == 0);
            if (fq.size() < 48 && $urandom_range(0, 9) < 6) fq.push_back($urandom());
            run(1);
        end
        en = 1'b1; flush = 1'b0; force_empty = 1'b0; hdr_ready = 1'b1;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
